dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 63 ++++++
 rtl/dmem_ram.sv | 33 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared load/store size encodings, FSM state codes and lane helpers for the
// data-memory responder and the instruction decoder that drives it.
package dmem_pkg;

    localparam logic [1:0] LD_NONE = 2'd0;
    localparam logic [1:0] LD_B    = 2'd1;
    localparam logic [1:0] LD_H    = 2'd2;
    localparam logic [1:0] LD_W    = 2'd3;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_W    = 2'd1;
    localparam logic [1:0] ST_H    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        sign;
        logic [31:0] wdata;
    } dmem_req_t;

    // A request that both loads and stores is treated like a misaligned one.
    function automatic logic is_illegal(input logic [1:0] rd, input logic [1:0] wr,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (rd != LD_NONE && wr != ST_NONE) begin
            bad = 1'b1;
        end else if (rd == LD_H || wr == ST_H) begin
            bad = lane[0];
        end else if (rd == LD_W || wr == ST_W) begin
            bad = (lane != 2'd0);
        end
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] wr, input logic [1:0] lane);
        logic [3:0] be;
        case (wr)
            ST_B:    be = 4'b0001 << lane;
            ST_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            ST_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned store data so every enabled lane sees it.
    function automatic logic [31:0] store_lanes(input logic [1:0] wr, input logic [31:0] wdata);
        logic [31:0] d;
        case (wr)
            ST_B:    d = {4{wdata[7:0]}};
            ST_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM: 32-bit words, per-byte write enables,
// registered read output that holds until the next read.
module dmem_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // An enabled cycle with no byte enables is a read.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// accesses the byte-lane RAM and returns extended load data with a fault flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [1:0]  mem_read_en,
    input  logic [1:0]  mem_write_en,
    input  logic        mem_sign,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        misaligned
);

    localparam int         WORD_AW   = ADDR_W - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              ld_ok_q, ld_ok_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dmem_req_t         req_q, req_d;

    logic        accept;
    logic        access;
    logic        illegal;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Upper address bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] rd,
                                                input logic sgn, input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (rd)
            LD_B:    res = sgn ? 32'(b) : {24'd0, b};
            LD_H:    res = sgn ? 32'(h) : {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        accept    = (state_q == IDLE) && req_valid &&
                    (mem_read_en != LD_NONE || mem_write_en != ST_NONE);
        access    = (state_q == WAIT) && (cnt_q == 4'd0);
        illegal   = is_illegal(req_q.rd, req_q.wr, addr_q[1:0]);
        // Reset on the access edge must suppress the write.
        ram_en    = access && !illegal && !rst;
        ram_we    = (req_q.wr != ST_NONE) ? byte_en(req_q.wr, addr_q[1:0]) : 4'b0000;
        ram_wdata = store_lanes(req_q.wr, req_q.wdata);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        ld_ok_d = ld_ok_q;
        addr_d  = addr_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = addr[ADDR_W-1:0];
                    req_d   = '{rd: mem_read_en, wr: mem_write_en, sign: mem_sign, wdata: wdata};
                    cnt_d   = WAIT_INIT;
                    mis_d   = 1'b0;
                    ld_ok_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mis_d   = illegal;
                    ld_ok_d = !illegal && (req_q.rd != LD_NONE);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mis_q   <= 1'b0;
            ld_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            ld_ok_q <= ld_ok_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        req_q  <= req_d;
    end

    dmem_ram #(
        .AW(WORD_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[ADDR_W-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register holds the loaded word for the whole RESP state.
    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign misaligned = rsp_valid && mis_q;
    assign rdata      = (rsp_valid && ld_ok_q) ?
                        load_extend(ram_rdata, req_q.rd, req_q.sign, addr_q[1:0]) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed load/store sequences with
// expected responses queued at issue and compared when the response appears.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAIT_CYCLES = 1;
    localparam int LAT         = WAIT_CYCLES + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [1:0]  mem_read_en;
    logic [1:0]  mem_write_en;
    logic        mem_sign;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        misaligned;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        s;
        logic [31:0] wd;
        logic [31:0] er;
        logic        em;
    } row_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W      (12),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .addr         (addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_sign     (mem_sign),
        .wdata        (wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rdata        (rdata),
        .misaligned   (misaligned)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after the response handshake.
    // lat counts negedges from the one right after the accepting edge.
    task automatic xact(input logic [31:0] a, input logic [1:0] rd, input logic [1:0] wr,
                        input logic s, input logic [31:0] wd, output logic [31:0] o_rd,
                        output logic o_mis, output int lat, output logic o_rdy);
        int n;
        req_valid = 1'b1; addr = a; mem_read_en = rd; mem_write_en = wr;
        mem_sign = s; wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0; mem_read_en = LD_NONE; mem_write_en = ST_NONE;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        o_rd  = rdata;
        o_mis = misaligned;
        @(negedge clk);
        o_rdy = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; addr = 32'h10; mem_read_en = LD_W;
        mem_write_en = ST_NONE; mem_sign = 1'b0; wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        checks++;
        if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
        rst = 1'b0; req_valid = 1'b0; mem_read_en = LD_NONE;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL reset_idle: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_ignore();
        req_valid = 1'b1; addr = 32'h10; mem_read_en = LD_NONE; mem_write_en = ST_NONE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
                begin errors++; $display("FAIL ignore_nop[%0d]: rsp_valid=%b req_ready=%b want 0/1", i, rsp_valid, req_ready); end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_sw_lw();
        row_t rows[$]; exp_t e; logic [31:0] o_rd; logic o_mis, o_rdy; int lat;
        rows.push_back(row_t'{32'h10, LD_NONE, ST_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0});
        rows.push_back(row_t'{32'h10, LD_W, ST_NONE, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0});
        foreach (rows[i]) begin
            sb_q.push_back(exp_t'{rows[i].er, rows[i].em});
            xact(rows[i].a, rows[i].rd, rows[i].wr, rows[i].s, rows[i].wd, o_rd, o_mis, lat, o_rdy);
            e = sb_q.pop_front();
            checks++;
            if (o_rd !== e.rdata || o_mis !== e.mis || lat != LAT || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL sw_lw[%0d]: rdata=%h mis=%b lat=%0d rdy=%b, want rdata=%h mis=%b lat=%0d rdy=1",
                         i, o_rd, o_mis, lat, o_rdy, e.rdata, e.mis, LAT);
            end
        end
    endtask

    task automatic test_extend();
        row_t rows[$]; exp_t e; logic [31:0] o_rd; logic o_mis, o_rdy; int lat;
        rows.push_back(row_t'{32'h13, LD_B, ST_NONE, 1'b1, 32'h0, 32'hFFFFFFDE, 1'b0});
        rows.push_back(row_t'{32'h13, LD_B, ST_NONE, 1'b0, 32'h0, 32'h000000DE, 1'b0});
        rows.push_back(row_t'{32'h10, LD_H, ST_NONE, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0});
        rows.push_back(row_t'{32'h12, LD_H, ST_NONE, 1'b0, 32'h0, 32'h0000DEAD, 1'b0});
        rows.push_back(row_t'{32'h10, LD_W, ST_NONE, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0});
        rows.push_back(row_t'{32'h11, LD_B, ST_NONE, 1'b1, 32'h0, 32'hFFFFFFBE, 1'b0});
        foreach (rows[i]) begin
            sb_q.push_back(exp_t'{rows[i].er, rows[i].em});
            xact(rows[i].a, rows[i].rd, rows[i].wr, rows[i].s, rows[i].wd, o_rd, o_mis, lat, o_rdy);
            e = sb_q.pop_front();
            checks++;
            if (o_rd !== e.rdata || o_mis !== e.mis || lat != LAT || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL extend[%0d]: rdata=%h mis=%b lat=%0d rdy=%b, want rdata=%h mis=%b lat=%0d rdy=1",
                         i, o_rd, o_mis, lat, o_rdy, e.rdata, e.mis, LAT);
            end
        end
    endtask

    task automatic test_partial();
        row_t rows[$]; exp_t e; logic [31:0] o_rd; logic o_mis, o_rdy; int lat;
        rows.push_back(row_t'{32'h11, LD_NONE, ST_B, 1'b0, 32'hAAAAAA55, 32'h0, 1'b0});
        rows.push_back(row_t'{32'h10, LD_W, ST_NONE, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0});
        rows.push_back(row_t'{32'h12, LD_NONE, ST_H, 1'b0, 32'hFFFF1234, 32'h0, 1'b0});
        rows.push_back(row_t'{32'h10, LD_W, ST_NONE, 1'b0, 32'h0, 32'h123455EF, 1'b0});
        rows.push_back(row_t'{32'h11, LD_B, ST_NONE, 1'b0, 32'h0, 32'h00000055, 1'b0});
        foreach (rows[i]) begin
            sb_q.push_back(exp_t'{rows[i].er, rows[i].em});
            xact(rows[i].a, rows[i].rd, rows[i].wr, rows[i].s, rows[i].wd, o_rd, o_mis, lat, o_rdy);
            e = sb_q.pop_front();
            checks++;
            if (o_rd !== e.rdata || o_mis !== e.mis || lat != LAT || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL partial[%0d]: rdata=%h mis=%b lat=%0d rdy=%b, want rdata=%h mis=%b lat=%0d rdy=1",
                         i, o_rd, o_mis, lat, o_rdy, e.rdata, e.mis, LAT);
            end
        end
    endtask

    task automatic test_errors();
        row_t rows[$]; exp_t e; logic [31:0] o_rd; logic o_mis, o_rdy; int lat;
        rows.push_back(row_t'{32'h11, LD_W, ST_NONE, 1'b0, 32'h0, 32'h0, 1'b1});
        rows.push_back(row_t'{32'h13, LD_NONE, ST_H, 1'b0, 32'h00009999, 32'h0, 1'b1});
        rows.push_back(row_t'{32'h10, LD_W, ST_W, 1'b0, 32'h0BADF00D, 32'h0, 1'b1});
        rows.push_back(row_t'{32'h11, LD_H, ST_NONE, 1'b1, 32'h0, 32'h0, 1'b1});
        rows.push_back(row_t'{32'h12, LD_NONE, ST_W, 1'b0, 32'h77777777, 32'h0, 1'b1});
        rows.push_back(row_t'{32'h10, LD_W, ST_NONE, 1'b0, 32'h0, 32'h123455EF, 1'b0});
        foreach (rows[i]) begin
            sb_q.push_back(exp_t'{rows[i].er, rows[i].em});
            xact(rows[i].a, rows[i].rd, rows[i].wr, rows[i].s, rows[i].wd, o_rd, o_mis, lat, o_rdy);
            e = sb_q.pop_front();
            checks++;
            if (o_rd !== e.rdata || o_mis !== e.mis || lat != LAT || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL errors[%0d]: rdata=%h mis=%b lat=%0d rdy=%b, want rdata=%h mis=%b lat=%0d rdy=1",
                         i, o_rd, o_mis, lat, o_rdy, e.rdata, e.mis, LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e; int n;
        rsp_ready = 1'b0;
        sb_q.push_back(exp_t'{32'h123455EF, 1'b0});
        req_valid = 1'b1; addr = 32'h10; mem_read_en = LD_W; mem_write_en = ST_NONE; mem_sign = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0; mem_read_en = LD_NONE;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rdata !== e.rdata || misaligned !== e.mis || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: rsp_valid=%b rdata=%h mis=%b req_ready=%b, want 1/%h/%b/0",
                         i, rsp_valid, rdata, misaligned, req_ready, e.rdata, e.mis);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL backpressure_release: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int acc_cyc[$]; int rsp_cnt; int cyc;
        req_valid = 1'b1; addr = 32'h12; mem_read_en = LD_H; mem_write_en = ST_NONE; mem_sign = 1'b1;
        rsp_cnt = 0; cyc = 0;
        while (rsp_cnt < 3 && cyc < 60) begin
            if (req_ready && req_valid) begin
                sb_q.push_back(exp_t'{32'h00001234, 1'b0});
                acc_cyc.push_back(cyc);
            end
            if (rsp_valid) begin
                e = sb_q.pop_front();
                rsp_cnt++;
                checks++;
                if (rdata !== e.rdata || misaligned !== e.mis)
                    begin errors++; $display("FAIL b2b_data[%0d]: rdata=%h mis=%b want %h/%b", rsp_cnt, rdata, misaligned, e.rdata, e.mis); end
            end
            if (rsp_cnt < 3) begin @(negedge clk); cyc++; end
        end
        req_valid = 1'b0; mem_read_en = LD_NONE;
        @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_cyc.size() <= i || acc_cyc[i] - acc_cyc[i-1] != WAIT_CYCLES + 3)
                begin errors++; $display("FAIL b2b_interval[%0d]: accepts=%0d want spacing %0d", i, acc_cyc.size(), WAIT_CYCLES + 3); end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$]; exp_t e; logic [31:0] o_rd; logic o_mis, o_rdy; int lat; int n;
        xact(32'h20, LD_NONE, ST_W, 1'b0, 32'h11111111, o_rd, o_mis, lat, o_rdy);
        req_valid = 1'b1; addr = 32'h20; mem_read_en = LD_NONE; mem_write_en = ST_W; wdata = 32'hCAFEF00D;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0; mem_write_en = ST_NONE;
        repeat (WAIT_CYCLES) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_mid_state: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_mid_dropped: rsp_valid=%b want 0", rsp_valid); end
        rows.push_back(row_t'{32'h20, LD_W, ST_NONE, 1'b0, 32'h0, 32'h11111111, 1'b0});
        rows.push_back(row_t'{32'h1020, LD_W, ST_NONE, 1'b0, 32'h0, 32'h11111111, 1'b0});
        rows.push_back(row_t'{32'hFFFFF024, LD_NONE, ST_W, 1'b0, 32'h22222222, 32'h0, 1'b0});
        rows.push_back(row_t'{32'h24, LD_W, ST_NONE, 1'b0, 32'h0, 32'h22222222, 1'b0});
        foreach (rows[i]) begin
            sb_q.push_back(exp_t'{rows[i].er, rows[i].em});
            xact(rows[i].a, rows[i].rd, rows[i].wr, rows[i].s, rows[i].wd, o_rd, o_mis, lat, o_rdy);
            e = sb_q.pop_front();
            checks++;
            if (o_rd !== e.rdata || o_mis !== e.mis || lat != LAT || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid[%0d]: rdata=%h mis=%b lat=%0d rdy=%b, want rdata=%h mis=%b lat=%0d rdy=1",
                         i, o_rd, o_mis, lat, o_rdy, e.rdata, e.mis, LAT);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; addr = 32'h0; mem_read_en = LD_NONE;
        mem_write_en = ST_NONE; mem_sign = 1'b0; wdata = 32'h0; rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_ignore();
        test_sw_lw();
        test_extend();
        test_partial();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
